rans_byte_reverser: RTL and testbench

- Sits directly downstream of the rANS encoder and consumes its enc_o/valid_o byte stream.
- rANS emits renormalisation bytes in reverse decode order, so this block buffers one block of encoder output in a LIFO.
- On flush, it replays the buffered bytes last-in-first-out over a valid/ready stream towards the DMA/AXI-stream packer.
- It also raises in_ready_o low so upstream can gate the encoder's en_i.

---
 rtl/rans_pkg.sv | 14 +
 rtl/rans_lifo_mem.sv | 29 ++
 rtl/rans_byte_reverser.sv | 151 +++++++++++++++
 tb/tb_rans_byte_reverser.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rans_pkg.sv
// Shared rANS definitions: reverser FSM states, header size and encoder defaults.
package rans_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HDR   = 2'd1,
        DRAIN = 2'd2
    } rev_state_e;

    localparam int HDR_BYTES        = 2;
    localparam int DEF_SYMBOL_WIDTH = 8;
    localparam int DEF_RESOLUTION   = 12;

endpackage

// File: rtl/rans_lifo_mem.sv
// LIFO storage: register array written at the fill pointer, registered read port.
// A read of the address being written in the same cycle returns the new byte.
module rans_lifo_mem #(
    parameter int SYMBOL_WIDTH = 8,
    parameter int DEPTH        = 1024,
    parameter int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [SYMBOL_WIDTH-1:0] wdata,
    input  logic                    rd_en,
    input  logic [AW-1:0]           raddr,
    output logic [SYMBOL_WIDTH-1:0] rdata
);

    logic [SYMBOL_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    rdata <= '0;
        else if (rd_en) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/rans_byte_reverser.sv
// Buffers one block of rANS encoder bytes and replays them last-in-first-out.
// Define RANS_REV_LEN_HDR_EN to prefix each block with a 2-byte LSB-first length header.
module rans_byte_reverser
    import rans_pkg::*;
#(
    parameter int SYMBOL_WIDTH = DEF_SYMBOL_WIDTH,
    parameter int DEPTH        = 1024,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    input  logic [SYMBOL_WIDTH-1:0] in_data_i,
    input  logic                    flush_i,
    output logic                    in_ready_o,
    output logic                    out_valid_o,
    output logic [SYMBOL_WIDTH-1:0] out_data_o,
    output logic                    out_last_o,
    input  logic                    out_ready_i,
    output logic [CNT_W-1:0]        count_o,
    output logic                    overflow_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    rev_state_e              state_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_push;
    logic                    push;
    logic                    pop;
    logic                    flush_go;
    logic                    rd_en;
    logic [AW-1:0]           raddr;
    logic [SYMBOL_WIDTH-1:0] rdata;
`ifdef RANS_REV_LEN_HDR_EN
    logic [2*SYMBOL_WIDTH-1:0] hdr_q;
    logic                      hdr_idx_q;
`endif

    assign in_ready_o = (state_q == FILL) && (count_q != FULL);
    assign push       = in_valid_i && in_ready_o;
    assign pop        = out_valid_o && out_ready_i;
    assign count_push = count_q + CNT_W'(push);
    assign count_o    = count_q;

`ifdef RANS_REV_LEN_HDR_EN
    assign flush_go = (state_q == FILL) && flush_i;
`else
    assign flush_go = (state_q == FILL) && flush_i && (count_push != '0);
`endif

    // Prefetch the top entry at flush (bypassing a same-cycle push), then the next one on every pop.
    assign rd_en = (flush_go && count_push != '0) ||
                   (state_q == DRAIN && pop && count_q > CNT_W'(1));
    assign raddr = flush_go ? AW'(count_push - CNT_W'(1)) : AW'(count_q - CNT_W'(2));

    rans_lifo_mem #(
        .SYMBOL_WIDTH (SYMBOL_WIDTH),
        .DEPTH        (DEPTH),
        .AW           (AW)
    ) u_mem (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we     (push),
        .waddr  (AW'(count_q)),
        .wdata  (in_data_i),
        .rd_en  (rd_en),
        .raddr  (raddr),
        .rdata  (rdata)
    );

`ifdef RANS_REV_LEN_HDR_EN
    assign out_data_o = (state_q == HDR) ?
                        (hdr_idx_q ? hdr_q[2*SYMBOL_WIDTH-1:SYMBOL_WIDTH] : hdr_q[SYMBOL_WIDTH-1:0]) :
                        rdata;
`else
    assign out_data_o = rdata;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FILL;
            count_q     <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            overflow_o  <= 1'b0;
`ifdef RANS_REV_LEN_HDR_EN
            hdr_q       <= '0;
            hdr_idx_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                FILL: begin
                    count_q <= count_push;
                    if (in_valid_i && !push) overflow_o <= 1'b1;
                    if (flush_go) begin
                        out_valid_o <= 1'b1;
`ifdef RANS_REV_LEN_HDR_EN
                        state_q    <= HDR;
                        hdr_q      <= (2*SYMBOL_WIDTH)'(count_push);
                        hdr_idx_q  <= 1'b0;
                        out_last_o <= 1'b0;
`else
                        state_q    <= DRAIN;
                        out_last_o <= (count_push == CNT_W'(1));
`endif
                    end
                end
`ifdef RANS_REV_LEN_HDR_EN
                HDR: begin
                    if (in_valid_i) overflow_o <= 1'b1;
                    if (pop) begin
                        if (hdr_idx_q == 1'(HDR_BYTES - 1)) begin
                            if (count_q == '0) begin
                                state_q     <= FILL;
                                out_valid_o <= 1'b0;
                                out_last_o  <= 1'b0;
                                overflow_o  <= 1'b0;
                            end else begin
                                state_q    <= DRAIN;
                                out_last_o <= (count_q == CNT_W'(1));
                            end
                        end else begin
                            hdr_idx_q  <= hdr_idx_q + 1'b1;
                            out_last_o <= (count_q == '0);
                        end
                    end
                end
`endif
                DRAIN: begin
                    // Bytes offered while draining are lost; flagged until the block is done.
                    if (in_valid_i) overflow_o <= 1'b1;
                    if (pop) begin
                        count_q <= count_q - CNT_W'(1);
                        if (count_q == CNT_W'(1)) begin
                            state_q     <= FILL;
                            out_valid_o <= 1'b0;
                            out_last_o  <= 1'b0;
                            overflow_o  <= 1'b0;
                        end else begin
                            out_last_o <= (count_q == CNT_W'(2));
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_rans_byte_reverser.sv
// Self-checking bench for rans_byte_reverser; the model is a plain byte queue reversed on flush.
module tb_rans_byte_reverser;

    localparam int SW    = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef RANS_REV_LEN_HDR_EN
    localparam int HB = 2;
`else
    localparam int HB = 0;
`endif

    typedef logic [SW-1:0] sym_t;

    logic             clk_i       = 1'b0;
    logic             rst_ni      = 1'b0;
    logic             in_valid_i  = 1'b0;
    sym_t             in_data_i   = '0;
    logic             flush_i     = 1'b0;
    logic             out_ready_i = 1'b0;
    logic             in_ready_o;
    logic             out_valid_o;
    sym_t             out_data_o;
    logic             out_last_o;
    logic [CNT_W-1:0] count_o;
    logic             overflow_o;

    int   n_chk = 0;
    int   n_err = 0;
    sym_t blk[$];
    bit   ovf_exp = 1'b0;
    bit   pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    rans_byte_reverser #(
        .SYMBOL_WIDTH (SW),
        .DEPTH        (DEPTH),
        .CNT_W        (CNT_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .flush_i     (flush_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i),
        .count_o     (count_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer bytes one per cycle; the model keeps only what fits and remembers drops.
    task automatic fill(input sym_t bytes[$], input bit flush_last);
        for (int i = 0; i < bytes.size(); i++) begin
            in_valid_i = 1'b1;
            in_data_i  = bytes[i];
            flush_i    = flush_last && (i == bytes.size() - 1);
            @(negedge clk_i);
            chk("fill_ready", 32'(in_ready_o), 32'(blk.size() != DEPTH));
            chk("fill_count", 32'(count_o), blk.size());
            chk("fill_ovf", 32'(overflow_o), 32'(ovf_exp));
            chk("fill_idle", 32'(out_valid_o), 0);
            @(posedge clk_i); #1;
            if (blk.size() < DEPTH) blk.push_back(bytes[i]);
            else                    ovf_exp = 1'b1;
        end
        in_valid_i = 1'b0;
        if (!flush_last || bytes.size() == 0) begin
            flush_i = 1'b1;
            @(posedge clk_i); #1;
        end
        flush_i = 1'b0;
    endtask

    // rdy_mode: 0 always ready, 1 fixed pattern, 2 random. inj: cycle to offer a stray input byte.
    task automatic drain(input int rdy_mode, input int inj, input int stop_after);
        sym_t exp[$];
        int   n, idx, cyc;
        n = blk.size();
        if (HB > 0) begin
            exp.push_back(sym_t'(n));
            exp.push_back(sym_t'(n >> SW));
        end
        for (int i = n - 1; i >= 0; i--) exp.push_back(blk[i]);
        idx = 0;
        cyc = 0;
        while (idx < exp.size() && cyc < 200 && idx != stop_after) begin
            case (rdy_mode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = (cyc < 7) ? pat[cyc] : 1'b1;
                default: out_ready_i = 1'($urandom_range(0, 1));
            endcase
            in_valid_i = (cyc == inj) && (idx < exp.size() - 1);
            in_data_i  = 8'hEE;
            @(negedge clk_i);
            chk("out_valid", 32'(out_valid_o), 1);
            chk("out_data", 32'(out_data_o), 32'(exp[idx]));
            chk("out_last", 32'(out_last_o), 32'(idx == exp.size() - 1));
            chk("drain_count", 32'(count_o), n - ((idx > HB) ? idx - HB : 0));
            chk("drain_in_ready", 32'(in_ready_o), 0);
            chk("drain_ovf", 32'(overflow_o), 32'(ovf_exp));
            @(posedge clk_i); #1;
            if (in_valid_i) ovf_exp = 1'b1;
            in_valid_i = 1'b0;
            if (out_ready_i) idx++;
            cyc++;
        end
        out_ready_i = 1'b0;
        if (idx == stop_after) return;
        if (idx < exp.size()) chk("drain_timeout", 0, 1);
        blk.delete();
        ovf_exp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("idle_valid", 32'(out_valid_o), 0);
            chk("idle_count", 32'(count_o), 0);
            chk("idle_ready", 32'(in_ready_o), 1);
            chk("idle_ovf", 32'(overflow_o), 0);
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        sym_t q[$];
        #3;
        chk("rst_valid", 32'(out_valid_o), 0);
        chk("rst_last", 32'(out_last_o), 0);
        chk("rst_data", 32'(out_data_o), 0);
        chk("rst_count", 32'(count_o), 0);
        chk("rst_ready", 32'(in_ready_o), 1);
        chk("rst_ovf", 32'(overflow_o), 0);
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Basic three-byte block at full rate
        q = '{8'h11, 8'h22, 8'h33};
        fill(q, 1'b0);
        drain(0, -1, -1);

        // Downstream stalls
        q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        fill(q, 1'b0);
        drain(1, -1, -1);

        // Overfill: fifth byte dropped and flagged
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        fill(q, 1'b0);
        drain(0, -1, -1);

        // Empty flush
        q.delete();
        fill(q, 1'b0);
        drain(0, -1, -1);

        // Push together with flush, stray input during drain
        q = '{8'h10, 8'h5A};
        fill(q, 1'b1);
        drain(0, 0, -1);

        // Reset in the middle of a drain
        q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        fill(q, 1'b0);
        drain(0, -1, 2 + HB);
        rst_ni = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid_o), 0);
        chk("midrst_count", 32'(count_o), 0);
        chk("midrst_data", 32'(out_data_o), 0);
        chk("midrst_last", 32'(out_last_o), 0);
        chk("midrst_ready", 32'(in_ready_o), 1);
        blk.delete();
        ovf_exp = 1'b0;
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        q = '{8'hD7, 8'hD8};
        fill(q, 1'b0);
        drain(0, -1, -1);

        // Random blocks
        for (int b = 0; b < 40; b++) begin
            int n;
            n = $urandom_range(0, DEPTH + 2);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(sym_t'($urandom));
            fill(q, 1'($urandom_range(0, 1)));
            drain(2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
